// File: rtl/retospect_bs_loader.sv
// Byte-stream to serial bitstream loader for a configuration scan chain, with
// optional capture of the bits shifted out of the chain's far end.
module retospect_bs_loader #(
    parameter int CHAIN_LEN = 523
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       rb_en,
    output logic       config_en,
    output logic       bs_out,
    input  logic       bs_ret,
    output logic       reset_nn,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, ARM, FIN} state_t;

    state_t        state_q, state_d;
    logic          rb_en_q, rb_en_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    sreg_q, sreg_d;
    logic [7:0]    rb_q, rb_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          config_en_q, reset_nn_q, busy_q, done_q;
    logic          last_bit;

    assign last_bit = (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d   = state_q;
        rb_en_d   = rb_en_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        rb_d      = rb_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    rb_en_d   = rb_en;
                    bit_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (s_valid && !m_valid_q) begin
                    sreg_d  = s_data;
                    rb_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d                 = {1'b0, sreg_q[7:1]};
                bit_cnt_d              = bit_cnt_q + 1'b1;
                rb_d[bit_cnt_q[2:0]]   = bs_ret;
                // Bytes stay aligned to the bit counter, so its low bits mark the byte end.
                if (bit_cnt_q[2:0] == 3'd7 || last_bit) begin
                    if (rb_en_q) begin
                        m_data_d  = rb_d;
                        m_valid_d = 1'b1;
                    end
                    state_d = last_bit ? GAP : LOAD;
                end
            end
            GAP: begin
                if (!m_valid_q) begin
                    state_d = ARM;
                end
            end
            ARM:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rb_en_q     <= 1'b0;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            rb_q        <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            config_en_q <= 1'b0;
            reset_nn_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rb_en_q     <= rb_en_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            rb_q        <= rb_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            config_en_q <= (state_d == SHIFT);
            reset_nn_q  <= (state_d == ARM);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == FIN);
        end
    end

    assign s_ready   = (state_q == LOAD) && !m_valid_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign config_en = config_en_q;
    // Hold the serial line low whenever the chain is not being clocked.
    assign bs_out    = config_en_q & sreg_q[0];
    assign reset_nn  = reset_nn_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_retospect_bs_loader.sv
// Bench for retospect_bs_loader on a 12-bit chain: expected bit streams and
// readback bytes come from a byte/bit-level model of a whole pass.
module tb_retospect_bs_loader;
    localparam int LEN   = 12;
    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       rb_en = 1'b0;
    logic       config_en;
    logic       bs_out;
    logic       bs_ret;
    logic       reset_nn;
    logic       busy;
    logic       done;

    retospect_bs_loader #(.CHAIN_LEN(LEN)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .rb_en(rb_en), .config_en(config_en), .bs_out(bs_out), .bs_ret(bs_ret),
        .reset_nn(reset_nn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream chain: bits enter at the near end and leave from the far end.
    logic [LEN-1:0] chain = '0;
    logic [LEN-1:0] preload = '0;
    logic           load_chain = 1'b0;
    assign bs_ret = chain[0];
    always @(posedge clk) begin
        if (load_chain) chain <= preload;
        else if (config_en) chain <= {bs_out, chain[LEN-1:1]};
    end

    // Monitor, sampling on the falling edge.
    int         cyc = 0;
    logic       bitsq[$];
    logic [7:0] rbq[$];
    int         last_shift = 0, rnn_n = 0, rnn_cyc = 0, done_n = 0, done_cyc = 0;
    int         gap_shifts = 0, stall_bad = 0;
    logic       in_gap = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_md = '0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (config_en) begin
            bitsq.push_back(bs_out);
            last_shift <= cyc;
            if (in_gap) gap_shifts <= gap_shifts + 1;
        end
        if (reset_nn) begin rnn_n <= rnn_n + 1; rnn_cyc <= cyc; end
        if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
        if (m_valid && m_ready) rbq.push_back(m_data);
        if (m_valid && !m_ready) begin
            if ((prev_stall && m_data != prev_md) || config_en || s_ready)
                stall_bad <= stall_bad + 1;
        end
        prev_stall <= m_valid && !m_ready;
        prev_md    <= m_data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {config_en, bs_out, reset_nn, s_ready, m_valid, m_data, busy, done}, 32'd0);
    endtask

    task automatic wait_ready(input int release_after, output int w);
        logic ok;
        w = 0;
        forever begin
            @(negedge clk);
            ok = s_ready;
            if (ok || w >= LIMIT) break;
            step();
            w++;
            if (w >= release_after) m_ready = 1'b1;
        end
    endtask

    task automatic run_pass(input int id, input logic rb, input logic [7:0] b0,
                            input logic [7:0] b1, input int gap, input int bp,
                            input logic [LEN-1:0] pre);
        int b_bits, b_rb, b_rnn, b_done, b_gap, b_stall, w;
        logic [7:0]     bytes[2];
        logic [LEN-1:0] got, exp;
        bytes[0] = b0; bytes[1] = b1;
        b_bits = bitsq.size(); b_rb = rbq.size(); b_rnn = rnn_n; b_done = done_n;
        b_gap = gap_shifts; b_stall = stall_bad;
        preload = pre; load_chain = 1'b1;
        step();
        load_chain = 1'b0;
        start = 1'b1; rb_en = rb; m_ready = (bp == 0);
        step();
        start = 1'b0; rb_en = ~rb;
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin
                wait_ready(bp == 0 ? 0 : 8 + bp, w);
                check("ready_wait", w < LIMIT, 1'b1);
                step();
                in_gap = 1'b1;
                repeat (gap) step();
                in_gap = 1'b0;
            end
            s_data = bytes[i]; s_valid = 1'b1;
            wait_ready(0, w);
            check("handshake_wait", w < LIMIT, 1'b1);
            step();
            s_valid = 1'b0;
        end
        m_ready = 1'b1;
        w = 0;
        while (done_n == b_done && w < LIMIT) begin step(); w++; end
        check("done_wait", w < LIMIT, 1'b1);
        repeat (3) step();
        exp = '0; got = '0;
        for (int k = 0; k < LEN; k++) begin
            exp[k] = bytes[k / 8][k % 8];
            if (b_bits + k < bitsq.size()) got[k] = bitsq[b_bits + k];
        end
        check("shift_count", bitsq.size() - b_bits, LEN);
        check("bit_stream", got, exp);
        check("reset_nn_pulses", rnn_n - b_rnn, 1);
        check("done_pulses", done_n - b_done, 1);
        check("done_after_rnn", done_cyc - rnn_cyc, 1);
        if (!rb) check("rnn_after_last_shift", rnn_cyc - last_shift, 2);
        check("readback_count", rbq.size() - b_rb, rb ? 2 : 0);
        if (rb && rbq.size() - b_rb == 2) begin
            check("readback_b0", rbq[b_rb], pre[7:0]);
            check("readback_b1", rbq[b_rb + 1], {4'h0, pre[LEN-1:8]});
        end
        check("gap_shifts", gap_shifts - b_gap, 0);
        check("stall_violations", stall_bad - b_stall, 0);
        check("busy_end", busy, 1'b0);
        $display("pass %0d: rb=%0b bytes=%02h,%02h gap=%0d bp=%0d bits=%03h rnn=%0d done=%0d",
                 id, rb, b0, b1, gap, bp, got, rnn_n - b_rnn, done_n - b_done);
    endtask

    initial begin
        int b_rnn, b_done, b_bits, w;
        repeat (2) step();
        check_idle_outputs("reset_outputs");
        reset = 1'b0;
        step();
        check_idle_outputs("idle_outputs");
        start = 1'b0;

        run_pass(1, 1'b0, 8'hA5, 8'h03, 0, 0, 12'h000);
        run_pass(2, 1'b1, 8'h3C, 8'h0A, 0, 0, 12'h5C3);
        run_pass(3, 1'b1, 8'($urandom), 8'($urandom), 0, 6, 12'($urandom));
        run_pass(4, 1'b0, 8'($urandom), 8'($urandom), 5, 0, 12'($urandom));

        // Abort mid-shift, then a clean pass.
        b_bits = bitsq.size();
        start = 1'b1; rb_en = 1'b1; m_ready = 1'b1;
        step();
        start = 1'b0;
        s_data = 8'hFF; s_valid = 1'b1;
        w = 0;
        while (bitsq.size() - b_bits < 5 && w < LIMIT) begin @(negedge clk); w++; end
        check("abort_shift_wait", w < LIMIT, 1'b1);
        step();
        reset = 1'b1; s_valid = 1'b0;
        b_rnn = rnn_n; b_done = done_n;
        step();
        check_idle_outputs("abort_reset_c1");
        step();
        reset = 1'b0;
        check_idle_outputs("abort_reset_c2");
        repeat (6) step();
        check("abort_no_rnn", rnn_n - b_rnn, 0);
        check("abort_no_done", done_n - b_done, 0);
        $display("abort: reset after 5 shifts, rnn=%0d done=%0d", rnn_n - b_rnn, done_n - b_done);
        run_pass(5, 1'b1, 8'($urandom), 8'($urandom), 2, 0, 12'($urandom));

        for (int p = 0; p < 3; p++) begin
            run_pass(6 + p, 1'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
